// File: rtl/nq_data_mem.sv
// Parametrised behavioural data memory with programmable wait states, a
// request/complete handshake and an error flag for out-of-range or colliding requests.
module nq_data_mem #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 16,
   parameter int DEPTH        = 64,
   parameter int WAIT_CYCLES  = 2,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write_mem,
   output logic              busy,
   output logic              valid,
   output logic              err,
   output logic [DATA_W-1:0] out_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              rd_q, wr_q;
   logic              err_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              commit;
   logic              from_wait;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_data;
   logic              op_rd, op_wr;
   logic              op_err;
   logic [IDX_W-1:0]  op_idx;

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      accept     = (state != S_WAIT) && (read || write);
      state_next = state;
      cnt_next   = cnt;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (WAIT_CYCLES > 0) begin
                  state_next = S_WAIT;
                  cnt_next   = CNT_LOAD;
               end else begin
                  state_next = S_DONE;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               state_next = S_DONE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Entering DONE straight from IDLE/DONE (zero wait states) uses the live
   // request; entering from WAIT uses the request latched at accept.
   always_comb begin
      from_wait = (state == S_WAIT);
      commit    = (state_next == S_DONE);
      op_addr   = from_wait ? addr_q : addr;
      op_data   = from_wait ? data_q : write_mem;
      op_rd     = from_wait ? rd_q   : read;
      op_wr     = from_wait ? wr_q   : write;
      op_err    = ({1'b0, op_addr} >= DEPTH_X) || (op_rd && op_wr);
      op_idx    = op_addr[IDX_W-1:0];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         data_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         out_data <= '0;
      end else begin
         if (accept) begin
            addr_q <= addr;
            data_q <= write_mem;
            rd_q   <= read;
            wr_q   <= write;
         end
         if (commit) begin
            err_q <= op_err;
            if (op_rd && !op_err) begin
               out_data <= mem[op_idx];
            end
         end
      end
   end

   // NOTE: the array is only cleared when CLEAR_ON_RST is set; otherwise reset
   // leaves it alone so contents survive, and an aborted write never lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (CLEAR_ON_RST != 0) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem[i] <= '0;
            end
         end
      end else if (commit && op_wr && !op_err) begin
         mem[op_idx] <= op_data;
      end
   end

   assign busy  = (state == S_WAIT);
   assign valid = (state == S_DONE);
   assign err   = valid && err_q;

endmodule

// File: tb/tb_nq_data_mem.sv
// Scoreboard bench for nq_data_mem: two instances (2 wait states / contents kept,
// 0 wait states / cleared on reset) share one stimulus stream, each with its own model.
module tb_nq_data_mem;

   logic        clk = 1'b0;
   logic        rst, read, write;
   logic [15:0] addr, wdata;
   logic        busy0, valid0, err0;
   logic        busy1, valid1, err1;
   logic [15:0] out0, out1;

   always #5 clk = ~clk;

   nq_data_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .WAIT_CYCLES(2), .CLEAR_ON_RST(0)) dut0 (
      .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .write_mem(wdata),
      .busy(busy0), .valid(valid0), .err(err0), .out_data(out0)
   );

   nq_data_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .WAIT_CYCLES(0), .CLEAR_ON_RST(1)) dut1 (
      .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .write_mem(wdata),
      .busy(busy1), .valid(valid1), .err(err1), .out_data(out1)
   );

   typedef struct {
      bit          err;
      bit          known;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;
   bit  mon_en = 1'b0;

   // Reference model state, one slot per instance.
   bit          pend      [2];
   int          done_at   [2];
   int          free_at   [2];
   logic [15:0] p_addr    [2];
   logic [15:0] p_data    [2];
   bit          p_rd      [2];
   bit          p_wr      [2];
   logic [15:0] mm        [2][64];
   bit          mk        [2][64];
   logic [15:0] exp_out   [2];
   bit          exp_known [2];
   bit          model_busy[2];

   function automatic int wait_of(int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic bit clear_of(int k);
      return (k == 0) ? 1'b0 : 1'b1;
   endfunction

   task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
      end
   endtask

   task automatic sb_push(int k, exp_t e);
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   function automatic int sb_size(int k);
      return (k == 0) ? sb0.size() : sb1.size();
   endfunction

   task automatic sb_pop(int k, output exp_t e);
      if (k == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
   endtask

   function automatic int sb_front_cyc(int k);
      return (k == 0) ? sb0[0].cyc : sb1[0].cyc;
   endfunction

   task automatic complete(int k);
      exp_t e;
      if (pend[k] && done_at[k] == cyc) begin
         e.err = (p_addr[k] >= 16'd64) || (p_rd[k] && p_wr[k]);
         if (!e.err) begin
            if (p_wr[k]) begin
               mm[k][p_addr[k][5:0]] = p_data[k];
               mk[k][p_addr[k][5:0]] = 1'b1;
            end else begin
               exp_out[k]   = mm[k][p_addr[k][5:0]];
               exp_known[k] = mk[k][p_addr[k][5:0]];
            end
         end
         e.data  = exp_out[k];
         e.known = exp_known[k];
         e.cyc   = cyc;
         sb_push(k, e);
         pend[k] = 1'b0;
      end
   endtask

   // Applies the effect of the clock edge that just happened, using the inputs
   // that were presented to it.
   task automatic model_edge(int k);
      if (rst) begin
         pend[k]       = 1'b0;
         free_at[k]    = 0;
         exp_out[k]    = 16'h0000;
         exp_known[k]  = 1'b1;
         model_busy[k] = 1'b0;
         if (clear_of(k)) begin
            for (int i = 0; i < 64; i++) begin
               mm[k][i] = 16'h0000;
               mk[k][i] = 1'b1;
            end
         end
         return;
      end
      complete(k);
      if ((read || write) && cyc >= free_at[k]) begin
         pend[k]    = 1'b1;
         done_at[k] = cyc + wait_of(k);
         free_at[k] = cyc + wait_of(k) + 1;
         p_addr[k]  = addr;
         p_data[k]  = wdata;
         p_rd[k]    = read;
         p_wr[k]    = write;
      end
      complete(k);
      model_busy[k] = pend[k] && (done_at[k] > cyc);
   endtask

   task automatic monitor(int k, logic b, logic v, logic e, logic [15:0] o);
      exp_t x;
      bit   exp_v;
      check("busy", k, 32'(b), 32'(model_busy[k]));
      exp_v = (sb_size(k) > 0) && (sb_front_cyc(k) == cyc);
      check("valid", k, 32'(v), 32'(exp_v));
      if (exp_v) begin
         sb_pop(k, x);
         if (v === 1'b1) begin
            check("err", k, 32'(e), 32'(x.err));
            if (x.known) check("out_data", k, 32'(o), 32'(x.data));
         end
      end else begin
         check("err_idle", k, 32'(e), 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         monitor(0, busy0, valid0, err0, out0);
         monitor(1, busy1, valid1, err1, out1);
      end
   end

   task automatic step(bit r, bit rd, bit wr, logic [15:0] a, logic [15:0] d);
      rst   = r;
      read  = rd;
      write = wr;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      cyc++;
      model_edge(0);
      model_edge(1);
      mon_en = 1'b1;
   endtask

   task automatic idle(int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      rst   = 1'b1;
      read  = 1'b0;
      write = 1'b0;
      addr  = 16'h0000;
      wdata = 16'h0000;
      for (int k = 0; k < 2; k++) begin
         pend[k]      = 1'b0;
         free_at[k]   = 0;
         done_at[k]   = 0;
         exp_known[k] = 1'b0;
         exp_out[k]   = 16'h0000;
         model_busy[k] = 1'b0;
         for (int i = 0; i < 64; i++) mk[k][i] = 1'b0;
      end

      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

      // Read after reset.
      step(1'b0, 1'b1, 1'b0, 16'd5, 16'h0000);
      idle(3);

      // Fill every word, holding each request until the slow instance accepts it.
      for (int a = 0; a < 64; a++) begin
         repeat (3) step(1'b0, 1'b0, 1'b1, 16'(a), (16'(a) * 16'h0101) ^ 16'h5A00);
      end
      idle(3);

      // Write then read the same word back-to-back from DONE.
      step(1'b0, 1'b0, 1'b1, 16'd3, 16'hBEEF);
      repeat (3) step(1'b0, 1'b1, 1'b0, 16'd3, 16'h0000);
      idle(3);

      // One read per cycle.
      for (int a = 0; a < 4; a++) step(1'b0, 1'b1, 1'b0, 16'(a), 16'h0000);
      idle(3);

      // Out-of-range, high-address aliasing, collision, then confirm mem[1].
      repeat (3) step(1'b0, 1'b1, 1'b0, 16'd64, 16'h0000);
      repeat (3) step(1'b0, 1'b1, 1'b0, 16'h8001, 16'h0000);
      repeat (3) step(1'b0, 1'b0, 1'b1, 16'h4001, 16'hAAAA);
      repeat (3) step(1'b0, 1'b1, 1'b1, 16'd1, 16'hDEAD);
      repeat (3) step(1'b0, 1'b1, 1'b0, 16'd1, 16'h0000);
      idle(3);

      // Reset during a pending write, then read the word back.
      step(1'b0, 1'b0, 1'b1, 16'd7, 16'h1234);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 16'd7, 16'h0000);
      idle(3);

      // Random traffic; requests toggle freely while busy.
      repeat (600) begin
         bit          r, rd, wr;
         logic [15:0] a, d;
         r  = ($urandom_range(0, 99) == 0);
         rd = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 3) == 0);
         a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
         d  = 16'($urandom);
         step(r, rd, wr, a, d);
      end
      idle(6);

      check("sb_drained", 0, 32'(sb0.size()), 32'd0);
      check("sb_drained", 1, 32'(sb1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
